// File: rtl/dbuf_pkg.sv
// Shared encodings for the double-buffer page shipper: FSM states and length width.
package dbuf_pkg;

    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_DRAIN   = 3'd2,
        S_DONE    = 3'd3,
        S_RELEASE = 3'd4,
        S_SETTLE  = 3'd5
    } state_t;

endpackage

// File: rtl/dbuf_page_shipper_if.sv
// Output word stream of the page shipper (valid/ready, with end-of-page marker).
interface dbuf_page_shipper_if #(
    parameter int DW = 64
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dbuf_skid_fifo.sv
// Small synchronous FIFO carrying data plus a last flag; head is presented combinationally.
// Head outputs read as zero while empty so the stream side idles at all-zero.
module dbuf_skid_fifo #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          empty,
    output logic [PW:0]   count
);

    logic [DW-1:0] mem      [DEPTH];
    logic          last_mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          full;
    logic          pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign pop     = rd_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr[PW-1:0]];
    assign rd_last = empty ? 1'b0 : last_mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[PW-1:0]]      <= wr_data;
            last_mem[wr_ptr[PW-1:0]] <= wr_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // The issuer's credit check must make a write into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/dbuf_page_shipper.sv
// Reader-side sequencer: ships one page from the double-buffer DPRAM to the stream, then releases it.
// Reads are credit-limited so the in-flight pipe plus skid FIFO can always absorb returning data.
module dbuf_page_shipper
    import dbuf_pkg::*;
#(
    parameter int P_RD_ADDR_WIDTH = 9,
    parameter int P_RD_DATA_WIDTH = 64,
    parameter int P_RD_LATENCY    = 1,
    parameter int P_FIFO_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       rd_busy,
    input  logic [LEN_W-1:0]           dpram_len,
    output logic [P_RD_ADDR_WIDTH-1:0] rd_addr,
    input  logic [P_RD_DATA_WIDTH-1:0] rd_dout,
    output logic                       done,
    dbuf_page_shipper_if.master        stream,
    output logic                       shipping,
    output logic                       len_err,
    output logic [31:0]                pages_shipped
);

    localparam int FCW = $clog2(P_FIFO_DEPTH) + 1;
    localparam int CW  = FCW + 1;
    localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(2**P_RD_ADDR_WIDTH);

    state_t                  state, state_nxt;
    logic [LEN_W:0]          len_q;
    logic [LEN_W:0]          issued;
    logic [LEN_W:0]          len_in;
    logic                    len_clamp;
    logic                    accept;
    logic                    issue;
    logic                    credit_ok;
    logic [P_RD_LATENCY-1:0] pipe_vld;
    logic [P_RD_LATENCY-1:0] pipe_last;
    logic [CW-1:0]           inflight;
    logic [FCW-1:0]          fifo_count;
    logic                    fifo_empty;

    assign len_clamp = ({1'b0, dpram_len} > MAX_LEN);
    assign len_in    = len_clamp ? MAX_LEN : {1'b0, dpram_len};
    assign rd_addr   = issued[P_RD_ADDR_WIDTH-1:0];
    assign shipping  = (state != S_IDLE);

    always_comb begin
        inflight = '0;
        for (int i = 0; i < P_RD_LATENCY; i++) inflight = inflight + CW'(pipe_vld[i]);
    end

    assign credit_ok = (CW'(fifo_count) + inflight) < CW'(P_FIFO_DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && rd_busy) begin
                    accept    = 1'b1;
                    state_nxt = (len_in == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (issued + 17'd1 == len_q) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN:   if (fifo_empty && inflight == '0) state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_RELEASE;
            end
            // Wait for the buffer to drop busy, then give its index one cycle to flip.
            S_RELEASE: if (!rd_busy) state_nxt = S_SETTLE;
            S_SETTLE:  state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q         <= '0;
            issued        <= '0;
            len_err       <= 1'b0;
            pages_shipped <= '0;
        end else begin
            if (accept) begin
                len_q  <= len_in;
                issued <= '0;
                if (len_clamp) len_err <= 1'b1;
            end else if (issue) begin
                issued <= issued + 17'd1;
            end
            if (done) pages_shipped <= pages_shipped + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld  <= '0;
            pipe_last <= '0;
        end else begin
            for (int i = P_RD_LATENCY - 1; i > 0; i--) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
            pipe_vld[0]  <= issue;
            pipe_last[0] <= issue && (issued == len_q - 17'd1);
        end
    end

    dbuf_skid_fifo #(
        .DW    (P_RD_DATA_WIDTH),
        .DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pipe_vld[P_RD_LATENCY-1]),
        .wr_data (rd_dout),
        .wr_last (pipe_last[P_RD_LATENCY-1]),
        .rd_en   (stream.tready),
        .rd_data (stream.tdata),
        .rd_last (stream.tlast),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign stream.tvalid = !fifo_empty;

endmodule

// File: tb/tb_dbuf_page_shipper.sv
// Bench: ping-pong DPRAM model with per-buffer expected word queues, compared every cycle against the stream.
module tb_dbuf_page_shipper;

    localparam int AW = 9;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          rd_busy;
    logic [15:0]   dpram_len;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_dout;
    logic          done;
    logic          shipping;
    logic          len_err;
    logic [31:0]   pages_shipped;

    dbuf_page_shipper_if #(.DW(DW)) stream ();

    dbuf_page_shipper #(
        .P_RD_ADDR_WIDTH (AW),
        .P_RD_DATA_WIDTH (DW),
        .P_RD_LATENCY    (1),
        .P_FIFO_DEPTH    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .rd_busy       (rd_busy),
        .dpram_len     (dpram_len),
        .rd_addr       (rd_addr),
        .rd_dout       (rd_dout),
        .done          (done),
        .stream        (stream),
        .shipping      (shipping),
        .len_err       (len_err),
        .pages_shipped (pages_shipped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Double-buffer model state
    int          rd_idx = 0;
    int          toggle_pending = 0;
    bit          full [2];
    int          blen [2];
    int          tag  [2];
    logic [64:0] q0 [$];
    logic [64:0] q1 [$];
    int          ready_pct = 100;
    int          done_cnt = 0;
    int          words_seen = 0;
    logic [63:0] last_data = '0;
    logic        last_flag = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [63:0] word_of(input int b, input int t, input int a);
        return {8'(b), 24'(t), 32'(a)};
    endfunction

    // Filling a buffer queues exactly the words the shipper must emit for it.
    task automatic fill(input int b, input int n);
        int m;
        m = (n > 512) ? 512 : n;
        tag[b]++;
        blen[b] = n;
        for (int i = 0; i < m; i++) begin
            if (b == 0) q0.push_back({(i == m - 1), word_of(b, tag[b], i)});
            else        q1.push_back({(i == m - 1), word_of(b, tag[b], i)});
        end
        full[b] = 1'b1;
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(q0.size() == 0 && q1.size() == 0 && !shipping) && n < budget);
        check(name, 64'(n >= budget), 64'd0);
    endtask

    // DPRAM (latency 1) and buffer-index model; release clears busy, the index flips a cycle later.
    initial begin
        logic [AW-1:0] addr_s;
        logic          done_s;
        rd_busy       = 1'b0;
        dpram_len     = '0;
        rd_dout       = '0;
        stream.tready = 1'b0;
        forever begin
            @(negedge clk);
            addr_s = rd_addr;
            done_s = done;
            @(posedge clk); #1;
            rd_dout = word_of(rd_idx, tag[rd_idx], int'(addr_s));
            if (toggle_pending != 0) begin
                rd_idx         = rd_idx ^ 1;
                toggle_pending = 0;
            end else if (done_s && !rst) begin
                full[rd_idx]   = 1'b0;
                toggle_pending = 1;
            end
            rd_busy       = full[rd_idx];
            dpram_len     = 16'(blen[rd_idx]);
            stream.tready = ($urandom_range(99) < ready_pct);
        end
    end

    // Per-cycle compare of the stream against the expected queue of the buffer being read.
    logic        prev_stall = 1'b0;
    logic        prev_done  = 1'b0;
    logic [63:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    always @(negedge clk) begin
        logic [64:0] e;
        logic        have;
        if (rst) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                check("done_one_cycle", 64'(prev_done), 64'd0);
            end
            if (stream.tvalid) begin
                if (prev_stall) begin
                    check("hold_data", stream.tdata, prev_data);
                    check("hold_last", 64'(stream.tlast), 64'(prev_last));
                end
                have = (rd_idx == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (!have) begin
                    checks++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no valid word", stream.tdata);
                end else if (stream.tready) begin
                    e = (rd_idx == 0) ? q0.pop_front() : q1.pop_front();
                    check("tdata", stream.tdata, e[63:0]);
                    check("tlast", 64'(stream.tlast), 64'(e[64]));
                    words_seen++;
                    last_data = stream.tdata;
                    last_flag = stream.tlast;
                end
            end
            prev_stall = stream.tvalid && !stream.tready;
            prev_data  = stream.tdata;
            prev_last  = stream.tlast;
            prev_done  = done;
        end
    end

    initial begin
        int n;
        int d0;
        int w0;
        bit found;
        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tvalid", 64'(stream.tvalid), 64'd0);
        check("rst_tdata", stream.tdata, 64'd0);
        check("rst_shipping", 64'(shipping), 64'd0);
        check("rst_pages", 64'(pages_shipped), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        rst    = 1'b0;
        enable = 1'b1;

        // T1 basic page, first-word latency pinned to 2 cycles
        ready_pct = 100;
        fill(rd_idx, 8);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!shipping && n < 20);
        check("t1_accept_timeout", 64'(n >= 20), 64'd0);
        n = 0;
        while (!stream.tvalid && n < 20) begin @(negedge clk); #1; n++; end
        check("t1_latency", 64'(n), 64'd2);
        wait_quiet("t1_timeout", 200);
        check("t1_pages", 64'(pages_shipped), 64'd1);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_word7", last_data, 64'h00000001_00000007);
        check("t1_word7_last", 64'(last_flag), 64'd1);

        // T2 backpressure
        ready_pct = 30;
        w0 = words_seen;
        fill(rd_idx, 16);
        wait_quiet("t2_timeout", 1000);
        check("t2_words", 64'(words_seen - w0), 64'd16);
        check("t2_pages", 64'(pages_shipped), 64'd2);

        // T3 zero length
        ready_pct = 100;
        d0 = done_cnt;
        fill(rd_idx, 0);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk); #1;
            if (done) found = 1'b1;
        end
        check("t3_done_seen", 64'(found), 64'd1);
        wait_quiet("t3_timeout", 100);
        check("t3_pages", 64'(pages_shipped), 64'd3);
        check("t3_done_cnt", 64'(done_cnt - d0), 64'd1);

        // T4 ping-pong, both halves filled
        ready_pct = 60;
        d0 = done_cnt;
        w0 = words_seen;
        fill(rd_idx, 5);
        fill(rd_idx ^ 1, 7);
        wait_quiet("t4_timeout", 1000);
        repeat (20) @(negedge clk);
        #1;
        check("t4_no_reship", 64'(shipping), 64'd0);
        check("t4_done_cnt", 64'(done_cnt - d0), 64'd2);
        check("t4_words", 64'(words_seen - w0), 64'd12);
        check("t4_pages", 64'(pages_shipped), 64'd5);
        check("t4_len_err", 64'(len_err), 64'd0);

        // T5 oversize page clamps to 512 words
        ready_pct = 100;
        w0 = words_seen;
        fill(rd_idx, 600);
        wait_quiet("t5_timeout", 2000);
        check("t5_words", 64'(words_seen - w0), 64'd512);
        check("t5_last_addr", 64'(last_data[31:0]), 64'd511);
        check("t5_last_flag", 64'(last_flag), 64'd1);
        check("t5_len_err", 64'(len_err), 64'd1);
        check("t5_pages", 64'(pages_shipped), 64'd6);

        // T6 reset after 3 words of a 10-word page
        ready_pct = 100;
        w0 = words_seen;
        fill(rd_idx, 10);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (words_seen - w0 < 3 && n < 100);
        check("t6_start_timeout", 64'(n >= 100), 64'd0);
        rst = 1'b1;
        #1;
        check("t6_tvalid", 64'(stream.tvalid), 64'd0);
        check("t6_tlast", 64'(stream.tlast), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_shipping", 64'(shipping), 64'd0);
        check("t6_rd_addr", 64'(rd_addr), 64'd0);
        check("t6_pages", 64'(pages_shipped), 64'd0);
        check("t6_len_err", 64'(len_err), 64'd0);
        full[0] = 1'b0;
        full[1] = 1'b0;
        rd_idx = 0;
        toggle_pending = 0;
        q0.delete();
        q1.delete();
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        w0 = words_seen;
        fill(0, 4);
        wait_quiet("t6_restart_timeout", 200);
        check("t6_restart_words", 64'(words_seen - w0), 64'd4);
        check("t6_restart_pages", 64'(pages_shipped), 64'd1);
        check("t6_restart_done", 64'(done_cnt - d0), 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
